// File: rtl/tick_gen_multi_if.sv
// tick_gen_multi_if: control/status bundle of the multi-channel tick generator.
interface tick_gen_multi_if #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 24,
   parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
   logic [NUM_CH-1:0] en;
   logic [NUM_CH-1:0] clear;
   logic [NUM_CH-1:0] oneshot;
   logic              period_wr;
   logic [CH_W-1:0]   period_ch;
   logic [CNT_W-1:0]  period_data;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] busy;
   modport master (
      output en, clear, oneshot, period_wr, period_ch, period_data,
      input  tick, busy
   );
   modport slave (
      input  en, clear, oneshot, period_wr, period_ch, period_data,
      output tick, busy
   );
endinterface

// File: rtl/tick_gen_multi.sv
// tick_gen_multi: NUM_CH independent programmable tick channels, periodic or one-shot.
module tick_gen_multi #(
   parameter int          NUM_CH         = 4,
   parameter int          CNT_W          = 24,
   parameter int unsigned DEFAULT_PERIOD = 1_000_000
) (
   input logic             clk,
   input logic             reset,
   tick_gen_multi_if.slave ctl
);
   localparam logic [1:0]       IDLE       = 2'd0;
   localparam logic [1:0]       RUN        = 2'd1;
   localparam logic [1:0]       DONE       = 2'd2;
   localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEFAULT_PERIOD);
   logic [NUM_CH-1:0] tick_v;
   logic [NUM_CH-1:0] busy_v;
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [1:0]       state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [CNT_W-1:0] act_q, act_d;
      logic [CNT_W-1:0] shd_q, shd_d;
      logic [CNT_W-1:0] last;
      logic             tick_q, tick_d;
      logic             term;
      // a period of 0 behaves as 1, so the terminal count is never below zero
      assign last  = (act_q == '0) ? '0 : act_q - CNT_W'(1);
      assign term  = (state_q == RUN) && (cnt_q == last);
      assign shd_d = (ctl.period_wr && (int'(ctl.period_ch) == c)) ? ctl.period_data : shd_q;
      always_comb begin
         state_d = state_q;
         cnt_d   = '0;
         act_d   = act_q;
         tick_d  = 1'b0;
         if (ctl.clear[c]) begin
            state_d = ctl.en[c] ? RUN : IDLE;
            act_d   = shd_q;
         end else if (!ctl.en[c]) begin
            state_d = IDLE;
         end else if (term) begin
            tick_d  = 1'b1;
            act_d   = shd_q;
            state_d = ctl.oneshot[c] ? DONE : RUN;
         end else if (state_q == RUN) begin
            cnt_d = cnt_q + CNT_W'(1);
         end else if (state_q != DONE) begin
            state_d = RUN;
            act_d   = shd_q;
         end
      end
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            act_q   <= RST_PERIOD;
            shd_q   <= RST_PERIOD;
            tick_q  <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            shd_q   <= shd_d;
            tick_q  <= tick_d;
         end
      end
      assign tick_v[c] = tick_q;
      assign busy_v[c] = (state_q == RUN);
   end
   assign ctl.tick = tick_v;
   assign ctl.busy = busy_v;
endmodule
